// File: rtl/signal_types_pkg.sv
// Shared types for the ADC capture path: packed two-channel sample word and
// capture FSM state encoding.
package signal_types_pkg;

    localparam int ADC_W = 14;

    typedef struct packed {
        logic [ADC_W-1:0] adc_ch1;
        logic [ADC_W-1:0] adc_ch0;
    } adc_sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Single-bit rising-edge detector: registers the previous level and flags
// a low-to-high transition combinationally in the cycle it is first seen.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/adc_capture_controller.sv
// Dual-channel ADC capture into a BRAM write port, ring or one-shot pass.
// Define ADC_CAP_TRIG_EN to make ARMED wait for a trig_i rising edge.
module adc_capture_controller
    import signal_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_en_i,
    input  logic                  cap_mode_i,
    input  logic [ADDR_WIDTH-1:0] cap_len_i,
    input  logic                  trig_i,
    input  logic                  adc_valid_i,
    input  logic [ADC_W-1:0]      adc_ch0_i,
    input  logic [ADC_W-1:0]      adc_ch1_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wr_en_o,
    output adc_sample_t           mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o
);

    cap_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    adc_sample_t           mem_data_q, mem_data_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;

    logic                  en_rise;
    logic                  trig_rise;
    logic                  arm_go;
    logic [ADDR_WIDTH-1:0] last_idx;

    rise_edge_det u_en_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (cap_en_i),
        .rise_o (en_rise)
    );

    rise_edge_det u_trig_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (trig_i),
        .rise_o (trig_rise)
    );

`ifdef ADC_CAP_TRIG_EN
    assign arm_go = trig_rise;
`else
    logic unused_trig_rise;
    assign unused_trig_rise = trig_rise;
    assign arm_go           = 1'b1;
`endif

    assign last_idx = len_q - ADDR_WIDTH'(1);

    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        mode_d      = mode_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_en_d = 1'b0;
        mem_data_d  = mem_data_q;
        wr_ptr_d    = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (en_rise && (cap_len_i != '0)) begin
                    state_d  = ARMED;
                    len_d    = cap_len_i;
                    mode_d   = cap_mode_i;
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                end
            end

            ARMED: begin
                if (!cap_en_i) begin
                    state_d = IDLE;
                end else if (arm_go) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end
            end

            CAPTURE: begin
                // Abort takes priority over a sample arriving in the same cycle.
                if (!cap_en_i) begin
                    state_d = IDLE;
                end else if (adc_valid_i) begin
                    mem_wr_en_d        = 1'b1;
                    mem_addr_d         = cnt_q;
                    mem_data_d.adc_ch0 = adc_ch0_i;
                    mem_data_d.adc_ch1 = adc_ch1_i;
                    wr_ptr_d           = cnt_q;
                    if (cnt_q == last_idx) begin
                        cnt_d = '0;
                        if (mode_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end

            DONE: begin
                if (!cap_en_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_data_q  <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_data_q  <= mem_data_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_data_o  = mem_data_q;
    assign wr_ptr_o    = wr_ptr_q;
    assign busy_o      = (state_q == ARMED) || (state_q == CAPTURE);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_adc_capture_controller.sv
// Scoreboard bench for adc_capture_controller: the driver queues expected
// BRAM writes, a negedge monitor pops and compares them as they appear.
module tb_adc_capture_controller;
    import signal_types_pkg::*;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_en;
    logic          cap_mode;
    logic [AW-1:0] cap_len;
    logic          trig;
    logic          adc_valid;
    logic [13:0]   adc_ch0;
    logic [13:0]   adc_ch1;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    adc_sample_t   mem_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] wr_ptr;

    adc_capture_controller #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_en_i    (cap_en),
        .cap_mode_i  (cap_mode),
        .cap_len_i   (cap_len),
        .trig_i      (trig),
        .adc_valid_i (adc_valid),
        .adc_ch0_i   (adc_ch0),
        .adc_ch1_i   (adc_ch1),
        .mem_addr_o  (mem_addr),
        .mem_wr_en_o (mem_wr_en),
        .mem_data_o  (mem_data),
        .busy_o      (busy),
        .done_o      (done),
        .wr_ptr_o    (wr_ptr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        adc_sample_t   data;
        int            cycle;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got write to addr 0x%0h, expected no write (cycle %0d)",
                             mem_addr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_data), 32'(e.data));
                    check("wr_cycle", cyc, e.cycle);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise cap_en, pass through ARMED and return once the DUT is in CAPTURE.
    task automatic arm(input logic mode, input logic [AW-1:0] len);
        cap_mode = mode;
        cap_len  = len;
        cap_en   = 1'b1;
        tick();
        check("armed_busy", 32'(busy), 32'd1);
        check("armed_wr_ptr_cleared", 32'(wr_ptr), 32'd0);
`ifdef ADC_CAP_TRIG_EN
        trig = 1'b1;
        tick();
        trig = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic send(input logic [AW-1:0] exp_addr, input logic [13:0] d0,
                        input logic [13:0] d1, input bit expect_write);
        exp_t e;
        adc_valid = 1'b1;
        adc_ch0   = d0;
        adc_ch1   = d1;
        if (expect_write) begin
            e.addr         = exp_addr;
            e.data.adc_ch0 = d0;
            e.data.adc_ch1 = d1;
            e.cycle        = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle_cycle();
        adc_valid = 1'b0;
        tick();
    endtask

    logic [AW-1:0] cont_addr [8];

    initial begin
        cont_addr = '{11'd0, 11'd1, 11'd2, 11'd0, 11'd1, 11'd2, 11'd0, 11'd1};
        rst_n     = 1'b0;
        cap_en    = 1'b0;
        cap_mode  = 1'b0;
        cap_len   = '0;
        trig      = 1'b0;
        adc_valid = 1'b0;
        adc_ch0   = '0;
        adc_ch1   = '0;
        #2;
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Continuous ring, len=3, eight samples back-to-back.
        arm(1'b0, 11'd3);
        for (int i = 0; i < 8; i++) send(cont_addr[i], 14'(16'h0100 + i), 14'(16'h2000 + i), 1'b1);
        idle_cycle();
        check("cont_done", 32'(done), 32'd0);
        check("cont_busy", 32'(busy), 32'd1);
        check("cont_wr_ptr", 32'(wr_ptr), 32'd1);
        cap_en = 1'b0;
        tick();
        check("cont_stop_busy", 32'(busy), 32'd0);

        // Snapshot, len=4: four writes then DONE, further valids ignored.
        arm(1'b1, 11'd4);
        for (int i = 0; i < 4; i++) send(AW'(i), 14'(16'h0A00 + i), 14'(16'h1500 + i), 1'b1);
        check("snap_done", 32'(done), 32'd1);
        check("snap_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) send('0, 14'h3ABC, 14'h0123, 1'b0);
        check("snap_done_hold", 32'(done), 32'd1);
        check("snap_wr_ptr", 32'(wr_ptr), 32'd3);
        adc_valid = 1'b0;
        cap_en    = 1'b0;
        tick();
        check("snap_release_done", 32'(done), 32'd0);

        // Zero length: the enable edge is ignored.
        cap_len   = '0;
        cap_mode  = 1'b1;
        cap_en    = 1'b1;
        adc_valid = 1'b1;
        repeat (5) tick();
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_done", 32'(done), 32'd0);
        cap_en    = 1'b0;
        adc_valid = 1'b0;
        tick();

        // Valid toggling, then abort with a write still in the output register.
        arm(1'b1, 11'd8);
        for (int i = 0; i < 3; i++) begin
            send(AW'(i), 14'(16'h0040 + i), 14'(16'h3F00 + i), 1'b1);
            idle_cycle();
        end
        send(11'd3, 14'h0043, 14'h3F03, 1'b1);
        cap_en = 1'b0;
        send('0, 14'h1111, 14'h2222, 1'b0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wr_ptr", 32'(wr_ptr), 32'd3);
        idle_cycle();

`ifdef ADC_CAP_TRIG_EN
        // Armed without trigger: no writes for 20 cycles, then trigger starts at 0.
        cap_mode = 1'b0;
        cap_len  = 11'd5;
        cap_en   = 1'b1;
        tick();
        adc_valid = 1'b1;
        repeat (20) tick();
        check("trig_wait_busy", 32'(busy), 32'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        send(11'd0, 14'h0777, 14'h0888, 1'b1);
        cap_en = 1'b0;
        idle_cycle();

        // Abort and trigger edge in the same cycle: abort wins.
        cap_en = 1'b1;
        tick();
        cap_en    = 1'b0;
        trig      = 1'b1;
        adc_valid = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        check("abort_vs_trig_busy", 32'(busy), 32'd0);
        idle_cycle();
`endif

        // Reset while the write of addr 5 sits in the output register.
        arm(1'b0, 11'd16);
        for (int i = 0; i < 5; i++) send(AW'(i), 14'(16'h0200 + i), 14'(16'h0300 + i), 1'b1);
        send(11'd5, 14'h0205, 14'h0305, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_data", 32'(mem_data), 32'd0);
        check("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        cap_en    = 1'b0;
        adc_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        arm(1'b1, 11'd2);
        send(11'd0, 14'h0AAA, 14'h0BBB, 1'b1);
        send(11'd1, 14'h0CCC, 14'h0DDD, 1'b1);
        idle_cycle();
        check("rearm_done", 32'(done), 32'd1);
        check("rearm_wr_ptr", 32'(wr_ptr), 32'd1);
        cap_en = 1'b0;

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
